// File: rtl/pe_input_feeder.sv
// pe_input_feeder: drives one convolution PE's ifmap and filter write ports
// from two upstream valid/ready streams, tags ifmap words with start/end-of-row
// bits, and sequences the PE start pulse and transfer completion.
module pe_input_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int PAR_WRITE  = 1,
    parameter int CNT_WIDTH  = 8,
    parameter int ROW_WIDTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ROW_WIDTH-1:0]              ifm_row_len,
    input  logic [CNT_WIDTH-1:0]              ifm_total,
    input  logic [CNT_WIDTH-1:0]              fil_total,
    input  logic                              src_ifm_valid,
    output logic                              src_ifm_ready,
    input  logic [DATA_WIDTH*PAR_WRITE-1:0]   src_ifm_data,
    input  logic                              src_fil_valid,
    output logic                              src_fil_ready,
    input  logic [DATA_WIDTH*PAR_WRITE-1:0]   src_fil_data,
    output logic                              pe_start,
    output logic                              w_en_ifm,
    output logic [DATA_WIDTH*PAR_WRITE+1:0]   data_in_ifm,
    input  logic                              ready_ifm,
    output logic                              w_en_fil,
    output logic [DATA_WIDTH*PAR_WRITE-1:0]   data_in_fil,
    input  logic                              ready_fil,
    output logic                              busy,
    output logic                              done
);

    localparam int PW = DATA_WIDTH * PAR_WRITE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [ROW_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] ifm_total_q;
    logic [CNT_WIDTH-1:0] fil_total_q;

    logic [CNT_WIDTH-1:0] ifm_taken;
    logic [CNT_WIDTH-1:0] ifm_sent;
    logic [ROW_WIDTH-1:0] col;
    logic                 ifm_hold_v;
    logic [PW+1:0]        ifm_hold_d;

    logic [CNT_WIDTH-1:0] fil_taken;
    logic [CNT_WIDTH-1:0] fil_sent;
    logic                 fil_hold_v;
    logic [PW-1:0]        fil_hold_d;

    logic                 start_accept;
    logic                 streaming;
    logic                 ifm_take;
    logic                 ifm_deliver;
    logic                 fil_take;
    logic                 fil_deliver;
    logic [ROW_WIDTH-1:0] len_eff;
    logic                 sor;
    logic                 eor;

    assign start_accept = (state == S_IDLE) && start;
    assign streaming    = (state == S_STREAM);

    // A hold register can be refilled in the same cycle it drains to the PE,
    // which is what sustains one word per cycle per channel.
    assign src_ifm_ready = streaming && (ifm_taken < ifm_total_q) &&
                           (!ifm_hold_v || ready_ifm);
    assign src_fil_ready = streaming && (fil_taken < fil_total_q) &&
                           (!fil_hold_v || ready_fil);

    assign ifm_take    = src_ifm_valid && src_ifm_ready;
    assign fil_take    = src_fil_valid && src_fil_ready;
    assign ifm_deliver = ifm_hold_v && ready_ifm;
    assign fil_deliver = fil_hold_v && ready_fil;

    // A zero row length behaves as a one-word row: every word is both first and last.
    assign len_eff = (len_q == '0) ? ROW_WIDTH'(1) : len_q;
    assign sor     = (col == '0);
    assign eor     = (col == len_eff - ROW_WIDTH'(1));

    assign w_en_ifm    = ifm_hold_v;
    assign data_in_ifm = ifm_hold_d;
    assign w_en_fil    = fil_hold_v;
    assign data_in_fil = fil_hold_d;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state decode; completion compares registered delivery counts.
    always_comb begin
        // NOTE: the default assignment first keeps this purely combinational
        // (no latch) even on paths that do not change state.
        state_next = state;
        unique case (state)
            S_IDLE:   if (start) state_next = S_START;
            S_START:  state_next = S_STREAM;
            S_STREAM: if (ifm_sent == ifm_total_q && fil_sent == fil_total_q)
                          state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Registered status outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            pe_start <= (state_next == S_START);
            busy     <= (state_next == S_START) || (state_next == S_STREAM);
            done     <= (state_next == S_DONE);
        end
    end

    // Transfer configuration, captured when start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            ifm_total_q <= '0;
            fil_total_q <= '0;
        end else if (start_accept) begin
            len_q       <= ifm_row_len;
            ifm_total_q <= ifm_total;
            fil_total_q <= fil_total;
        end
    end

    // Ifmap channel: hold register, row position and take/send counters.
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            // NOTE: the data hold register is reset too, because it drives
            // data_in_ifm directly and that port must read zero out of reset.
            ifm_hold_v <= 1'b0;
            ifm_hold_d <= '0;
            ifm_taken  <= '0;
            ifm_sent   <= '0;
            col        <= '0;
        end else begin
            if (ifm_take) begin
                ifm_hold_v <= 1'b1;
                ifm_hold_d <= {sor, eor, src_ifm_data};
                ifm_taken  <= ifm_taken + CNT_WIDTH'(1);
                col        <= eor ? '0 : col + ROW_WIDTH'(1);
            end else if (ifm_deliver) begin
                ifm_hold_v <= 1'b0;
            end
            if (ifm_deliver) ifm_sent <= ifm_sent + CNT_WIDTH'(1);
        end
    end

    // Filter channel: hold register and take/send counters, no tags.
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            fil_hold_v <= 1'b0;
            fil_hold_d <= '0;
            fil_taken  <= '0;
            fil_sent   <= '0;
        end else begin
            if (fil_take) begin
                fil_hold_v <= 1'b1;
                fil_hold_d <= src_fil_data;
                fil_taken  <= fil_taken + CNT_WIDTH'(1);
            end else if (fil_deliver) begin
                fil_hold_v <= 1'b0;
            end
            if (fil_deliver) fil_sent <= fil_sent + CNT_WIDTH'(1);
        end
    end

endmodule
